// File: rtl/mc_debug_pkg.sv
// Shared definitions for the multi-cycle CPU debug/trace blocks.
package mc_debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  function automatic int unsigned entry_width(input int unsigned nch,
                                              input int unsigned data_w,
                                              input int unsigned state_w);
    return nch * data_w + state_w;
  endfunction

endpackage

// File: rtl/mc_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port, no reset so it maps to RAM.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 100,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-address read in the write cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mc_trace_buffer.sv
// Pre/post-trigger trace capture of CPU probe channels into a circular buffer.
module mc_trace_buffer
  import mc_debug_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NCH     = 3,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            arm,
  input  logic                            mode,
  input  logic                            sample_en,
  input  logic [NCH*DATA_W-1:0]           ch_data,
  input  logic [STATE_W-1:0]              ch_state,
  input  logic [DATA_W-1:0]               trig_value,
  input  logic [AW-1:0]                   post_len,
  input  logic [AW-1:0]                   rd_addr,
  output logic [NCH*DATA_W+STATE_W-1:0]   rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            triggered,
  output logic [AW:0]                     count,
  output logic [AW-1:0]                   trig_index
);

  localparam int unsigned EW   = entry_width(NCH, DATA_W, STATE_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_t  state_q, state_n;
  logic [AW-1:0] wr_ptr_q, wr_ptr_n;
  logic [AW:0]   count_n;
  logic [AW-1:0] post_q, post_n;
  logic [AW-1:0] trig_phys_q, trig_phys_n;
  logic          trig_n;
  logic          sample, hit;
  logic [AW-1:0] oldest, oldest_n, raddr;
  logic [EW-1:0] ram_q;
  logic          rd_valid;

  assign sample = ((state_q == ARMED) || (state_q == POST)) && (!mode || sample_en);
  assign hit    = (state_q == ARMED) && sample && (ch_data[DATA_W-1:0] == trig_value);

  always_comb begin
    state_n     = state_q;
    wr_ptr_n    = wr_ptr_q;
    count_n     = count;
    post_n      = post_q;
    trig_phys_n = trig_phys_q;
    trig_n      = triggered;
    if (sample) begin
      wr_ptr_n = wr_ptr_q + AW'(1);
      count_n  = (count == FULL) ? count : count + (AW+1)'(1);
    end
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_n  = ARMED;
          wr_ptr_n = '0;
          count_n  = '0;
          trig_n   = 1'b0;
        end
      end
      ARMED: begin
        if (hit) begin
          trig_n      = 1'b1;
          trig_phys_n = wr_ptr_q;
          if (post_len == '0) begin
            state_n = DONE;
          end else begin
            state_n = POST;
            post_n  = post_len;
          end
        end
      end
      POST: begin
        if (sample) begin
          post_n = post_q - AW'(1);
          if (post_q == AW'(1)) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // trig_index is derived from the post-update pointers so it is right in the DONE entry cycle.
  assign oldest_n = (count_n == FULL) ? wr_ptr_n : '0;
  assign oldest   = (count == FULL) ? wr_ptr_q : '0;
  assign raddr    = oldest + rd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count       <= '0;
      post_q      <= '0;
      trig_phys_q <= '0;
      triggered   <= 1'b0;
      trig_index  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      state_q     <= state_n;
      wr_ptr_q    <= wr_ptr_n;
      count       <= count_n;
      post_q      <= post_n;
      trig_phys_q <= trig_phys_n;
      triggered   <= trig_n;
      busy        <= (state_n == ARMED) || (state_n == POST);
      done        <= (state_n == DONE);
      rd_valid    <= 1'b1;
      if ((state_n == DONE) && (state_q != DONE)) trig_index <= trig_phys_n - oldest_n;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (sample),
    .waddr (wr_ptr_q),
    .wdata ({ch_state, ch_data}),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // The RAM read register has no reset; masking until the first post-reset edge gives rd_data=0 in reset.
  assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_mc_trace_buffer.sv
// Directed, table-driven checks of mc_trace_buffer capture, wrap and readback.
module tb_mc_trace_buffer;

  localparam int DATA_W = 32;
  localparam int NCH    = 3;
  localparam int SW     = 4;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int EW     = NCH * DATA_W + SW;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  arm;
  logic                  mode;
  logic                  sample_en;
  logic [NCH*DATA_W-1:0] ch_data;
  logic [SW-1:0]         ch_state;
  logic [DATA_W-1:0]     trig_value;
  logic [AW-1:0]         post_len;
  logic [AW-1:0]         rd_addr;
  logic [EW-1:0]         rd_data;
  logic                  busy, done, triggered;
  logic [AW:0]           count;
  logic [AW-1:0]         trig_index;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_trace_buffer #(
    .DATA_W  (DATA_W),
    .NCH     (NCH),
    .STATE_W (SW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .mode       (mode),
    .sample_en  (sample_en),
    .ch_data    (ch_data),
    .ch_state   (ch_state),
    .trig_value (trig_value),
    .post_len   (post_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .triggered  (triggered),
    .count      (count),
    .trig_index (trig_index)
  );

  typedef struct {
    logic        mode;
    logic [31:0] trig;
    logic [3:0]  post;
    int          pat;
    int          exp_cycles;
    int          exp_count;
    int          exp_ti;
    int          first;
  } scen_t;

  scen_t scen [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry encoding: {state, ch2, ch1, ch0} derived from one probe value.
  function automatic logic [EW-1:0] mk(input logic [31:0] v);
    logic [3:0] st;
    st = v[3:0] ^ 4'h9;
    return {st, v + 32'd1000, ~v, v};
  endfunction

  function automatic logic [31:0] val(input int pat, input int k);
    case (pat)
      1:       return (k % 4 == 0) ? 32'(100 + k / 4) : 32'd103;
      3:       return (k <= 2) ? 32'(k) : 32'd2;
      default: return 32'(k);
    endcase
  endfunction

  function automatic logic [31:0] stored(input int pat, input int first, input int i);
    if (pat == 3) return (i <= 2) ? 32'(i) : 32'd2;
    return 32'(first + i);
  endfunction

  task automatic drive(input int pat, input int k);
    logic [EW-1:0] e;
    e         = mk(val(pat, k));
    ch_data   = e[NCH*DATA_W-1:0];
    ch_state  = e[EW-1:NCH*DATA_W];
    sample_en = (k % 4 == 0);
  endtask

  task automatic run_scenario(input int idx, input scen_t s);
    int cyc;
    @(negedge clk);
    mode = s.mode; trig_value = s.trig; post_len = s.post; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk($sformatf("s%0d_arm_count", idx), 128'(count), 128'd0);
    chk($sformatf("s%0d_arm_busy", idx), 128'(busy), 128'd1);
    chk($sformatf("s%0d_arm_done", idx), 128'(done), 128'd0);
    chk($sformatf("s%0d_arm_trig", idx), 128'(triggered), 128'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      drive(s.pat, cyc);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("s%0d_done", idx), 128'(done), 128'd1);
    chk($sformatf("s%0d_cycles", idx), 128'(cyc), 128'(s.exp_cycles));
    chk($sformatf("s%0d_busy", idx), 128'(busy), 128'd0);
    chk($sformatf("s%0d_triggered", idx), 128'(triggered), 128'd1);
    chk($sformatf("s%0d_count", idx), 128'(count), 128'(s.exp_count));
    chk($sformatf("s%0d_trig_index", idx), 128'(trig_index), 128'(s.exp_ti));
    for (int i = 0; i < s.exp_count; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      chk($sformatf("s%0d_rd%0d", idx, i), 128'(rd_data), 128'(mk(stored(s.pat, s.first, i))));
    end
    chk($sformatf("s%0d_done_hold", idx), 128'(done), 128'd1);
  endtask

  initial begin
    //          mode trig post pat cyc cnt ti first
    scen[0] = '{1'b0, 32'd5,   4'd3, 0, 9,  9,  5, 0};
    scen[1] = '{1'b0, 32'd40,  4'd7, 0, 48, 16, 8, 32};
    scen[2] = '{1'b1, 32'd103, 4'd2, 1, 21, 6,  3, 100};
    scen[3] = '{1'b0, 32'd0,   4'd0, 0, 1,  1,  0, 0};
    scen[4] = '{1'b0, 32'd2,   4'd3, 3, 6,  6,  2, 0};

    reset = 1'b0; arm = 1'b0; mode = 1'b0; sample_en = 1'b0;
    ch_data = '0; ch_state = '0; trig_value = '0; post_len = '0; rd_addr = '0;

    #2  arm = 1'b1;
    #5  arm = 1'b0;
    #5  arm = 1'b1;
    #2;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_rd_data", 128'(rd_data), 128'd0);
    chk("rst_triggered", 128'(triggered), 128'd0);
    #2  arm = 1'b0;
    #1  reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_done", 128'(done), 128'd0);

    for (int i = 0; i < 5; i++) run_scenario(i, scen[i]);

    // Abort a capture in POST with reset, then capture again normally.
    @(negedge clk);
    mode = 1'b0; trig_value = 32'd2; post_len = 4'd10; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, k);
      @(negedge clk);
    end
    chk("mid_post_busy", 128'(busy), 128'd1);
    chk("mid_post_triggered", 128'(triggered), 128'd1);
    chk("mid_post_count", 128'(count), 128'd5);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_triggered", 128'(triggered), 128'd0);
    chk("abort_count", 128'(count), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 128'(busy), 128'd0);
    chk("abort_idle_done", 128'(done), 128'd0);
    run_scenario(5, scen[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
